// File: rtl/control_input_pkg.sv
// Shared encodings for the button conditioning block: rotate codes, cursor
// pulse bit positions, button indices and the cursor state machine states.
package control_input_pkg;

    localparam logic [1:0] ROT_UP    = 2'd0;
    localparam logic [1:0] ROT_RIGHT = 2'd1;
    localparam logic [1:0] ROT_DOWN  = 2'd2;
    localparam logic [1:0] ROT_LEFT  = 2'd3;

    localparam int KEY_RIGHT_BIT = 0;
    localparam int KEY_LEFT_BIT  = 1;

    localparam int NUM_BTN    = 5;
    localparam int BTN_UP     = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_DECIDE = 4;

    typedef enum logic [1:0] {
        IDLE,
        HELD_R,
        HELD_L,
        BLOCKED
    } cursor_state_e;

    // Simultaneous direction rises resolve up > right > down > left.
    function automatic logic [1:0] rotate_select(input logic [3:0] dirRise);
        if (dirRise[BTN_UP])         return ROT_UP;
        else if (dirRise[BTN_RIGHT]) return ROT_RIGHT;
        else if (dirRise[BTN_DOWN])  return ROT_DOWN;
        else                         return ROT_LEFT;
    endfunction

endpackage

// File: rtl/control_input_if.sv
// Raw board buttons in, conditioned game controls out.
interface control_input_if;

    logic       btn_up_in;
    logic       btn_right_in;
    logic       btn_down_in;
    logic       btn_left_in;
    logic       btn_decide_in;
    logic       enable_in;
    logic [1:0] rotate_out;
    logic [1:0] key_input_out;
    logic       decide_out;

    modport master (
        output btn_up_in, btn_right_in, btn_down_in, btn_left_in, btn_decide_in, enable_in,
        input  rotate_out, key_input_out, decide_out
    );

    modport slave (
        input  btn_up_in, btn_right_in, btn_down_in, btn_left_in, btn_decide_in, enable_in,
        output rotate_out, key_input_out, decide_out
    );

endinterface

// File: rtl/control_input_button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for one raw button,
// with a one-cycle rise flag derived from a registered copy of the level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;

    // The level only flips after the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_out = level_q;
    assign rise_out  = level_q & ~prev_q;

endmodule

// File: rtl/control_input.sv
// Turns five raw buttons into a held shield direction, cursor step pulses
// with hold-to-repeat, and a single confirm pulse for the game controller.
module control_input
    import control_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_RATE     = 9750000,
    parameter int CNT_W           = 26
) (
    input  logic            clk,
    input  logic            rst,
    control_input_if.slave  bus
);

    localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [NUM_BTN-1:0] rawBtn;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic               unusedLevels;

    logic [1:0]         rotate_q;
    logic               decide_q;
    logic [1:0]         key_q;
    cursor_state_e      state_q;
    logic [CNT_W-1:0]   rptCnt_q;

    assign rawBtn = {bus.btn_decide_in, bus.btn_left_in, bus.btn_down_in,
                     bus.btn_right_in, bus.btn_up_in};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw_in   (rawBtn[g]),
            .level_out(level[g]),
            .rise_out (rise[g])
        );
    end

    assign unusedLevels = ^{level[BTN_UP], level[BTN_DOWN], level[BTN_DECIDE]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rotate_q <= ROT_UP;
            decide_q <= 1'b0;
        end else begin
            if (bus.enable_in && (|rise[3:0])) begin
                rotate_q <= rotate_select(rise[3:0]);
            end
            decide_q <= bus.enable_in & rise[BTN_DECIDE];
        end
    end

    // Cursor steps: one pulse per accepted press, then auto-repeat while held.
    // The repeat counter reloads so that after the first long delay it only
    // has REPEAT_RATE cycles left to run before the next pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rptCnt_q <= '0;
            key_q    <= 2'b00;
        end else if (!bus.enable_in) begin
            state_q  <= IDLE;
            rptCnt_q <= '0;
            key_q    <= 2'b00;
        end else begin
            key_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (rise[BTN_RIGHT] && rise[BTN_LEFT]) begin
                        state_q <= BLOCKED;
                    end else if (rise[BTN_RIGHT]) begin
                        key_q[KEY_RIGHT_BIT] <= 1'b1;
                        state_q              <= HELD_R;
                        rptCnt_q             <= '0;
                    end else if (rise[BTN_LEFT]) begin
                        key_q[KEY_LEFT_BIT] <= 1'b1;
                        state_q             <= HELD_L;
                        rptCnt_q            <= '0;
                    end
                end
                HELD_R: begin
                    if (rise[BTN_LEFT]) begin
                        key_q[KEY_LEFT_BIT] <= 1'b1;
                        state_q             <= HELD_L;
                        rptCnt_q            <= '0;
                    end else if (!level[BTN_RIGHT]) begin
                        state_q  <= IDLE;
                        rptCnt_q <= '0;
                    end else if (rptCnt_q == RPT_FIRST) begin
                        key_q[KEY_RIGHT_BIT] <= 1'b1;
                        rptCnt_q             <= RPT_RELOAD;
                    end else begin
                        rptCnt_q <= rptCnt_q + 1'b1;
                    end
                end
                HELD_L: begin
                    if (rise[BTN_RIGHT]) begin
                        key_q[KEY_RIGHT_BIT] <= 1'b1;
                        state_q              <= HELD_R;
                        rptCnt_q             <= '0;
                    end else if (!level[BTN_LEFT]) begin
                        state_q  <= IDLE;
                        rptCnt_q <= '0;
                    end else if (rptCnt_q == RPT_FIRST) begin
                        key_q[KEY_LEFT_BIT] <= 1'b1;
                        rptCnt_q            <= RPT_RELOAD;
                    end else begin
                        rptCnt_q <= rptCnt_q + 1'b1;
                    end
                end
                BLOCKED: begin
                    if (!level[BTN_RIGHT] && !level[BTN_LEFT]) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rptCnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.rotate_out    = rotate_q;
    assign bus.key_input_out = key_q;
    assign bus.decide_out    = decide_q;

endmodule
